// File: rtl/fp_add_pkg.sv
// Shared formats and types for the pipelined binary32 adder.
// Operands are unpacked once in stage 1; later stages work on sign, exponent and significand.
package fp_add_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 2 * BIAS + 1;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W:0]  sig;
        fp_class_t        cls;
    } fp_unpacked_t;

    // Subnormals are flushed to signed zero; normals get the hidden 1 prepended.
    function automatic fp_unpacked_t unpack(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign = v[31];
        u.exp  = v[FRAC_W +: EXP_W];
        u.sig  = {1'b1, v[FRAC_W-1:0]};
        u.cls  = NORM;
        if (v[FRAC_W +: EXP_W] == '0) begin
            u.cls = ZERO;
            u.exp = '0;
            u.sig = '0;
        end else if (v[FRAC_W +: EXP_W] == '1) begin
            u.cls = (v[FRAC_W-1:0] == '0) ? INF : NAN;
        end
        return u;
    endfunction

endpackage

// File: rtl/floating_point_addition_if.sv
// Operand/result bundle of the binary32 adder.
// master drives operands and consumes the sum; slave is the adder side.
interface floating_point_addition_if;

    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        z_valid;

    modport master (output x, y, input z, z_valid);
    modport slave  (input x, y, output z, z_valid);

endinterface

// File: rtl/fp_add_norm_round.sv
// Stage 4 combinational datapath: leading-zero normalize, round-to-nearest-even,
// overflow/underflow saturation and substitution of special results.
module fp_add_norm_round
    import fp_add_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [27:0]       sum,
    input  logic              spec,
    input  logic [31:0]       spec_val,
    output logic [31:0]       result
);

    logic [4:0]         lz;
    logic               found;
    logic [26:0]        m;
    logic signed [9:0]  e;
    logic               round_up;
    logic [24:0]        rounded;
    logic [FRAC_W-1:0]  frac;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
    end

    // Bit 26 of m is the hidden 1; bits [2:0] are guard, round and sticky.
    always_comb begin
        m        = '0;
        e        = '0;
        round_up = 1'b0;
        rounded  = '0;
        frac     = '0;

        if (sum[27]) begin
            m = {sum[27:2], |sum[1:0]};
            e = $signed({2'b00, exp}) + 10'sd1;
        end else begin
            m = sum[26:0] << lz;
            e = $signed({2'b00, exp}) - $signed({5'b00000, lz});
        end

        round_up = m[2] & (m[1] | m[0] | m[3]);
        rounded  = {1'b0, m[26:3]} + 25'(round_up);
        if (rounded[24]) begin
            frac = rounded[23:1];
            e    = e + 10'sd1;
        end else begin
            frac = rounded[22:0];
        end

        if (spec) begin
            result = spec_val;
        end else if (sum == '0) begin
            result = 32'h0000_0000;
        end else if (int'(e) >= EXP_MAX) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (e <= 10'sd0) begin
            result = {sign, 31'b0};
        end else begin
            result = {sign, e[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/floating_point_addition.sv
// Four-stage pipelined binary32 adder: unpack, align, add, normalize/round.
// One operation accepted and one retired per clock; special cases bypass the datapath.
module floating_point_addition
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z,
    output logic        z_valid
);

    // Stage 1: classify and decide special results
    fp_unpacked_t ua, ub;
    logic         spec_n;
    logic [31:0]  spec_val_n;

    always_comb begin
        ua         = unpack(x);
        ub         = unpack(y);
        spec_n     = 1'b1;
        spec_val_n = '0;
        if (ua.cls == NAN || ub.cls == NAN ||
            (ua.cls == INF && ub.cls == INF && ua.sign != ub.sign))
            spec_val_n = QNAN;
        else if (ua.cls == INF)
            spec_val_n = {ua.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (ub.cls == INF)
            spec_val_n = {ub.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (ua.cls == ZERO && ub.cls == ZERO)
            spec_val_n = {ua.sign & ub.sign, 31'b0};
        else if (ua.cls == ZERO)
            spec_val_n = y;
        else if (ub.cls == ZERO)
            spec_val_n = x;
        else
            spec_n = 1'b0;
    end

    fp_unpacked_t s1_a, s1_b;
    logic         s1_spec;
    logic [31:0]  s1_spec_val;

    // Stage 2: order by magnitude and align the smaller significand
    logic             a_ge;
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W-1:0] diff;
    logic [FRAC_W:0]  big_sig;
    logic [FRAC_W:0]  small_sig;
    fp_class_t        small_cls;
    logic [26:0]      m_small;
    logic [26:0]      shifted;
    logic [26:0]      lost;
    logic [26:0]      mb_n;

    always_comb begin
        a_ge       = {s1_a.exp, s1_a.sig} >= {s1_b.exp, s1_b.sig};
        big_sign   = a_ge ? s1_a.sign : s1_b.sign;
        small_sign = a_ge ? s1_b.sign : s1_a.sign;
        big_exp    = a_ge ? s1_a.exp  : s1_b.exp;
        big_sig    = a_ge ? s1_a.sig  : s1_b.sig;
        small_sig  = a_ge ? s1_b.sig  : s1_a.sig;
        small_cls  = a_ge ? s1_b.cls  : s1_a.cls;
        diff       = big_exp - (a_ge ? s1_b.exp : s1_a.exp);
        m_small    = {small_sig, 3'b000};
        shifted    = m_small >> diff;
        lost       = m_small & ~({27{1'b1}} << diff);
        if (diff >= 8'd26)
            mb_n = {26'b0, small_cls == NORM};
        else
            mb_n = {shifted[26:1], shifted[0] | (|lost)};
    end

    logic             s2_sign;
    logic             s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [26:0]      s2_ma;
    logic [26:0]      s2_mb;
    logic             s2_spec;
    logic [31:0]      s2_spec_val;

    // Stage 3: magnitude add or subtract; A is never smaller than B
    logic [27:0] sum_n;

    always_comb begin
        if (s2_sub)
            sum_n = {1'b0, s2_ma} - {1'b0, s2_mb};
        else
            sum_n = {1'b0, s2_ma} + {1'b0, s2_mb};
    end

    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [27:0]      s3_sum;
    logic             s3_spec;
    logic [31:0]      s3_spec_val;

    // Stage 4
    logic [31:0] z_n;

    fp_add_norm_round u_norm_round (
        .sign     (s3_sign),
        .exp      (s3_exp),
        .sum      (s3_sum),
        .spec     (s3_spec),
        .spec_val (s3_spec_val),
        .result   (z_n)
    );

    logic [3:0] vld;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_a        <= '0;
            s1_b        <= '0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_exp      <= '0;
            s2_ma       <= '0;
            s2_mb       <= '0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
            s3_sign     <= 1'b0;
            s3_exp      <= '0;
            s3_sum      <= '0;
            s3_spec     <= 1'b0;
            s3_spec_val <= '0;
            z           <= '0;
            vld         <= '0;
        end else begin
            s1_a        <= ua;
            s1_b        <= ub;
            s1_spec     <= spec_n;
            s1_spec_val <= spec_val_n;

            s2_sign     <= big_sign;
            s2_sub      <= big_sign ^ small_sign;
            s2_exp      <= big_exp;
            s2_ma       <= {big_sig, 3'b000};
            s2_mb       <= mb_n;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;

            s3_sign     <= s2_sign;
            s3_exp      <= s2_exp;
            s3_sum      <= sum_n;
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;

            z           <= z_n;
            vld         <= {vld[2:0], 1'b1};
        end
    end

    assign z_valid = vld[3];

endmodule

// File: tb/tb_floating_point_addition.sv
// Directed bench for the pipelined binary32 adder: latency, arithmetic, rounding,
// special values, back-to-back streaming and mid-stream reset.
module tb_floating_point_addition;

    logic clk = 1'b0;
    logic reset;

    floating_point_addition_if bus ();

    floating_point_addition dut (
        .clk     (clk),
        .reset   (reset),
        .x       (bus.x),
        .y       (bus.y),
        .z       (bus.z),
        .z_valid (bus.z_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    localparam int N = 17;
    logic [31:0] vx [N];
    logic [31:0] vy [N];
    logic [31:0] vz [N];

    // Hand-computed vectors: 0..4 arithmetic, 5..8 rounding, 9..16 specials.
    task automatic fill_tables();
        vx = '{32'h1FFF_FFFF, 32'h3F80_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000,
               32'h7F80_0000, 32'h7F7F_FFFF, 32'h0000_0001, 32'h8000_0000,
               32'h7FC1_2345, 32'hFF80_0000, 32'h0000_0000, 32'h0080_0001};
        vy = '{32'h9FFF_FFF0, 32'h3F80_0000, 32'hBF80_0000, 32'h4010_0000, 32'hC000_0000,
               32'h3380_0000, 32'h33C0_0000, 32'h3380_0000, 32'h2F80_0000,
               32'hFF80_0000, 32'h7F7F_FFFF, 32'h0000_0000, 32'h8000_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'hC049_0FDB, 32'h8080_0000};
        vz = '{32'h15F0_0000, 32'h4000_0000, 32'h0000_0000, 32'h4070_0000, 32'hBF80_0000,
               32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0002, 32'h3F80_0000,
               32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,
               32'h7FC0_0000, 32'hFF80_0000, 32'hC049_0FDB, 32'h0000_0000};
    endtask

    task automatic test_reset();
        logic exp_v;
        reset = 1'b0;
        bus.x = 32'h3F80_0000;
        bus.y = 32'h3F80_0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.z !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_z: z=%h expected 00000000", bus.z);
        end
        checks++;
        if (bus.z_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: z_valid=%b expected 0", bus.z_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            exp_v = (i == 4);
            checks++;
            if (bus.z_valid !== exp_v) begin
                errors++;
                $display("FAIL valid_rise edge %0d: z_valid=%b expected %b", i, bus.z_valid, exp_v);
            end
        end
    endtask

    // Single operation surrounded by zeros: result present on exactly one edge.
    task automatic test_latency();
        @(negedge clk);
        bus.x = 32'h0;
        bus.y = 32'h0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.x = vx[0];
        bus.y = vy[0];
        @(posedge clk);
        @(negedge clk);
        bus.x = 32'h0;
        bus.y = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.z !== 32'h0000_0000) begin
            errors++;
            $display("FAIL latency_early: z=%h expected 00000000", bus.z);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.z !== vz[0]) begin
            errors++;
            $display("FAIL latency_on_time: z=%h expected %h", bus.z, vz[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.z !== 32'h0000_0000) begin
            errors++;
            $display("FAIL latency_late: z=%h expected 00000000", bus.z);
        end
    endtask

    task automatic test_arith();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.x = vx[i];
            bus.y = vy[i];
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (bus.z !== vz[i]) begin
                errors++;
                $display("FAIL arith[%0d]: %h + %h gave z=%h expected %h", i, vx[i], vy[i], bus.z, vz[i]);
            end
        end
    endtask

    task automatic test_rounding();
        for (int i = 5; i <= 8; i++) begin
            @(negedge clk);
            bus.x = vx[i];
            bus.y = vy[i];
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (bus.z !== vz[i]) begin
                errors++;
                $display("FAIL round[%0d]: %h + %h gave z=%h expected %h", i, vx[i], vy[i], bus.z, vz[i]);
            end
        end
    endtask

    task automatic test_specials();
        for (int i = 9; i < N; i++) begin
            @(negedge clk);
            bus.x = vx[i];
            bus.y = vy[i];
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (bus.z !== vz[i]) begin
                errors++;
                $display("FAIL special[%0d]: %h + %h gave z=%h expected %h", i, vx[i], vy[i], bus.z, vz[i]);
            end
        end
    endtask

    // New operands every cycle; vector j must appear after edge j+3.
    task automatic test_back_to_back();
        for (int c = 0; c < N + 3; c++) begin
            @(negedge clk);
            bus.x = (c < N) ? vx[c] : 32'h0;
            bus.y = (c < N) ? vy[c] : 32'h0;
            @(posedge clk);
            #1;
            if (c >= 3) begin
                checks++;
                if (bus.z !== vz[c-3]) begin
                    errors++;
                    $display("FAIL stream[%0d]: z=%h expected %h", c - 3, bus.z, vz[c-3]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.x = vx[c + 1];
            bus.y = vy[c + 1];
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.z !== 32'h0000_0000 || bus.z_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: z=%h z_valid=%b expected 00000000 0", bus.z, bus.z_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.x = 32'h3F80_0000;
        bus.y = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.z_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid_low: z_valid=%b expected 0", bus.z_valid);
        end
        checks++;
        if (bus.z !== 32'h0000_0000) begin
            errors++;
            $display("FAIL mid_reset_discard: z=%h expected 00000000", bus.z);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.z_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_valid_high: z_valid=%b expected 1", bus.z_valid);
        end
        checks++;
        if (bus.z !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mid_reset_first: z=%h expected 40000000", bus.z);
        end
    endtask

    initial begin
        fill_tables();
        test_reset();
        test_latency();
        test_arith();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
